// File: rtl/serial_subtractor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_ctrl
// Brief    : Bit-serial WIDTH-bit subtractor; one full_subtractor cell is
//            time-shared LSB first, one bit per clock.
// Revision : 1.0
// ============================================================================

module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);
    assign D    = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);
endmodule

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out
);
    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic w_d;
    logic w_bout;

    full_subtractor u_cell (
        .A    (a_sr_q[0]),
        .B    (b_sr_q[0]),
        .Bin  (borrow_q),
        .D    (w_d),
        .Bout (w_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            borrow_q <= 1'b0;
            res_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            borrow_q <= borrow_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        borrow_d = borrow_q;
        res_d    = res_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    a_sr_d   = a_in;
                    b_sr_d   = b_in;
                    borrow_d = borrow_in;
                    cnt_d    = '0;
                end
            end
            S_RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                borrow_d = w_bout;
                res_d    = {w_d, res_q[WIDTH-1:1]};
                if (cnt_q == LAST) begin
                    // Count is held at the last bit so it never wraps.
                    state_d = S_DONE;
                    diff_d  = {w_d, res_q[WIDTH-1:1]};
                    bout_d  = w_bout;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy       = (state_q == S_RUN) || (state_q == S_DONE);
    assign done       = (state_q == S_DONE);
    assign diff_out   = diff_q;
    assign borrow_out = bout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor_ctrl
// Brief    : Self-checking bench for serial_subtractor_ctrl (WIDTH=8 and 4).
// Revision : 1.0
// ============================================================================

module tb_serial_subtractor_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;
    logic       start4, bin4, busy4, done4, bout4;
    logic [3:0] a4, b4, diff4;

    int checks = 0;
    int errors = 0;

    logic [7:0] held_d;
    logic       held_b;

    always #5 clk = ~clk;

    serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8),
        .borrow_in(bin8), .busy(busy8), .done(done8),
        .diff_out(diff8), .borrow_out(bout8)
    );

    serial_subtractor_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4),
        .borrow_in(bin4), .busy(busy4), .done(done4),
        .diff_out(diff4), .borrow_out(bout4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One WIDTH=8 operation; optionally fires a stray start in RUN cycle 3.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit inject);
        int  n;
        bit  got;
        int  ed;
        int  eb;
        ed = ((int'(a) - int'(b) - int'(bin)) + 512) % 256;
        eb = (int'(a) < int'(b) + int'(bin)) ? 1 : 0;
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        n = 0; got = 0;
        while (n < 12 && !got) begin
            @(negedge clk);
            n++;
            if (done8) begin
                got = 1;
            end else begin
                chk("run_busy", {31'd0, busy8}, 32'd1);
                if (n == 4) chk("run_diff_held", {24'd0, diff8}, {24'd0, held_d});
            end
            start8 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            if (inject && n == 3) start8 = 1'b1;
        end
        chk("done_seen", {31'd0, got}, 32'd1);
        chk("latency", n, 9);
        chk("diff", {24'd0, diff8}, ed);
        chk("borrow", {31'd0, bout8}, eb);
        @(negedge clk);
        chk("post_busy", {30'd0, busy8, done8}, 32'd0);
        chk("post_hold", {23'd0, bout8, diff8}, {23'd0, 1'(eb), 8'(ed)});
        held_d = 8'(ed);
        held_b = 1'(eb);
    endtask

    initial begin
        int  n;
        bit  got;
        int  ea, eb4, ebin, ed, ebr;
        rst = 1'b1;
        start8 = 0; a8 = 0; b8 = 0; bin8 = 0;
        start4 = 0; a4 = 0; b4 = 0; bin4 = 0;
        held_d = 8'd0; held_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset8", {22'd0, busy8, done8, bout8, diff8}, 32'd0);
        chk("reset4", {26'd0, busy4, done4, bout4, diff4}, 32'd0);
        rst = 1'b0;

        // Directed corner cases
        op8(8'd5,   8'd3,   1'b0, 1'b0);
        op8(8'd3,   8'd5,   1'b0, 1'b0);
        op8(8'h00,  8'h00,  1'b1, 1'b0);
        op8(8'hFF,  8'hFF,  1'b0, 1'b0);
        op8(8'h80,  8'h01,  1'b0, 1'b0);
        op8(8'h12,  8'h34,  1'b1, 1'b1);

        // Randomized operations, some with a stray start during RUN
        for (int i = 0; i < 40; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));

        // Reset in RUN cycle 4 aborts the operation
        op8(8'h9A, 8'h21, 1'b0, 1'b0);
        @(negedge clk);
        a8 = 8'h40; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start8 = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_state", {22'd0, busy8, done8, bout8, diff8}, 32'd0);
        got = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) got = 1;
        end
        chk("abort_no_done", {31'd0, got}, 32'd0);
        held_d = 8'd0; held_b = 1'b0;
        op8(8'h40, 8'h11, 1'b0, 1'b0);

        // Exhaustive 4-bit sweep with start tied high
        start4 = 1'b1;
        for (int i = 0; i < 512; i++) begin
            ea = i % 16; eb4 = (i / 16) % 16; ebin = i / 256;
            a4 = 4'(ea); b4 = 4'(eb4); bin4 = 1'(ebin);
            ed  = ((ea - eb4 - ebin) % 16 + 16) % 16;
            ebr = (ea < eb4 + ebin) ? 1 : 0;
            n = 0; got = 0;
            while (n < 10 && !got) begin
                @(negedge clk);
                n++;
                got = done4;
            end
            chk("sweep_done", {31'd0, got}, 32'd1);
            chk("sweep_gap", n, (i == 0) ? 5 : 6);
            chk("sweep_diff", {27'd0, bout4, diff4}, {27'd0, 1'(ebr), 4'(ed)});
        end
        start4 = 1'b0;
        repeat (8) @(negedge clk);
        chk("sweep_idle", {31'd0, busy4}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
